// File: rtl/ifetch_pkg.sv
// Shared constants for the fetch/decode front end: type-bit indices, format one-hots, opcode/funct fields.
// RV32M bit indices exist only when IFETCH_RV32M_EN is defined.
package ifetch_pkg;

  localparam int DEC_TYPE_BITS = 31;

  localparam int T_AND  = 0;
  localparam int T_OR   = 1;
  localparam int T_SRA  = 2;
  localparam int T_SRL  = 3;
  localparam int T_XOR  = 4;
  localparam int T_SLT  = 5;
  localparam int T_SLL  = 6;
  localparam int T_SUB  = 7;
  localparam int T_ADD  = 8;
  localparam int T_SRAI = 9;
  localparam int T_SRLI = 10;
  localparam int T_SLLI = 11;
  localparam int T_ANDI = 12;
  localparam int T_ORI  = 13;
  localparam int T_XORI = 14;
  localparam int T_SLTI = 15;
  localparam int T_ADDI = 16;
  localparam int T_SW   = 17;
  localparam int T_LW   = 18;
  localparam int T_BNE  = 19;
  localparam int T_BEQ  = 20;
  localparam int T_JALR = 21;
  localparam int T_JAL  = 22;
`ifdef IFETCH_RV32M_EN
  localparam int T_MUL    = 23;
  localparam int T_MULH   = 24;
  localparam int T_MULHSU = 25;
  localparam int T_MULHU  = 26;
  localparam int T_DIV    = 27;
  localparam int T_DIVU   = 28;
  localparam int T_REM    = 29;
  localparam int T_REMU   = 30;
`endif

  localparam logic [4:0] FMT_J = 5'b00001;
  localparam logic [4:0] FMT_B = 5'b00010;
  localparam logic [4:0] FMT_S = 5'b00100;
  localparam logic [4:0] FMT_I = 5'b01000;
  localparam logic [4:0] FMT_R = 5'b10000;

  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  typedef struct packed {
    logic [DEC_TYPE_BITS-1:0] itype;
    logic [4:0]               format;
    logic                     illegal;
  } dec_info_t;

endpackage

// File: rtl/ifetch_decode_queue_if.sv
// Bus bundle between the fetch/decode queue, instruction memory, redirect source and execute stage.
interface ifetch_decode_queue_if #(
  parameter int ADDR_W = 32,
  parameter int TYPE_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  // dec_*: an entry moves when dec_valid && dec_ready on a rising edge; while dec_valid && !dec_ready the
  // head fields hold still, and dec_valid only falls after a transfer or on redirect/reset.
  logic              dec_valid;
  logic              dec_ready;
  logic [ADDR_W-1:0] dec_pc;
  logic [31:0]       dec_instr;
  logic [TYPE_W-1:0] dec_type;
  logic [4:0]        dec_format;
  logic              dec_illegal;

  modport master (
    output imem_req, imem_addr, dec_valid, dec_pc, dec_instr, dec_type, dec_format, dec_illegal,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_pc, dec_instr, dec_type, dec_format, dec_illegal,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/ifd_decoder.sv
// Combinational RV32I pre-decoder: instruction word -> one-hot type, one-hot format, illegal flag.
// IFETCH_RV32M_EN adds the funct7=0x01 multiply/divide group.
module ifd_decoder
  import ifetch_pkg::*;
(
  input  logic [31:0] instr,
  output dec_info_t   info
);
  logic [6:0]               opcode;
  logic [2:0]               funct3;
  logic [6:0]               funct7;
  logic [DEC_TYPE_BITS-1:0] itype;
  logic [4:0]               fmt;
  logic                     unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    itype = '0;
    fmt   = '0;
    case (opcode)
      OP_JAL: begin
        itype[T_JAL] = 1'b1;
        fmt          = FMT_J;
      end
      OP_JALR: begin
        if (funct3 == 3'd0) itype[T_JALR] = 1'b1;
        fmt = FMT_I;
      end
      OP_BRANCH: begin
        if (funct3 == 3'd0)      itype[T_BEQ] = 1'b1;
        else if (funct3 == 3'd1) itype[T_BNE] = 1'b1;
        fmt = FMT_B;
      end
      OP_LOAD: begin
        if (funct3 == 3'd2) itype[T_LW] = 1'b1;
        fmt = FMT_I;
      end
      OP_STORE: begin
        if (funct3 == 3'd2) itype[T_SW] = 1'b1;
        fmt = FMT_S;
      end
      OP_IMM: begin
        fmt = FMT_I;
        case (funct3)
          3'd0: itype[T_ADDI] = 1'b1;
          3'd2: itype[T_SLTI] = 1'b1;
          3'd4: itype[T_XORI] = 1'b1;
          3'd6: itype[T_ORI]  = 1'b1;
          3'd7: itype[T_ANDI] = 1'b1;
          3'd1: if (funct7 == F7_BASE) itype[T_SLLI] = 1'b1;
          3'd5: begin
            if (funct7 == F7_BASE)     itype[T_SRLI] = 1'b1;
            else if (funct7 == F7_ALT) itype[T_SRAI] = 1'b1;
          end
          default: ;
        endcase
      end
      OP_REG: begin
        fmt = FMT_R;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'd0: itype[T_ADD] = 1'b1;
            3'd1: itype[T_SLL] = 1'b1;
            3'd2: itype[T_SLT] = 1'b1;
            3'd4: itype[T_XOR] = 1'b1;
            3'd5: itype[T_SRL] = 1'b1;
            3'd6: itype[T_OR]  = 1'b1;
            3'd7: itype[T_AND] = 1'b1;
            default: ;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'd0)      itype[T_SUB] = 1'b1;
          else if (funct3 == 3'd5) itype[T_SRA] = 1'b1;
        end else if (funct7 == F7_MULDIV) begin
`ifdef IFETCH_RV32M_EN
          case (funct3)
            3'd0: itype[T_MUL]    = 1'b1;
            3'd1: itype[T_MULH]   = 1'b1;
            3'd2: itype[T_MULHSU] = 1'b1;
            3'd3: itype[T_MULHU]  = 1'b1;
            3'd4: itype[T_DIV]    = 1'b1;
            3'd5: itype[T_DIVU]   = 1'b1;
            3'd6: itype[T_REM]    = 1'b1;
            default: itype[T_REMU] = 1'b1;
          endcase
`else
          itype = '0;
`endif
        end
      end
      default: ;
    endcase
  end

  // Format is only reported for a fully matched word, so an illegal word carries all-zero type and format.
  assign info.itype   = itype;
  assign info.format  = (itype != '0) ? fmt : 5'b00000;
  assign info.illegal = (itype == '0);

endmodule

// File: rtl/ifetch_decode_queue.sv
// Fetch/decode front end: PC generation, one-deep in-flight tracking and a circular queue of pre-decoded words.
// Optional RV32M decode is enabled by defining IFETCH_RV32M_EN.
module ifetch_decode_queue
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 4,
  parameter int                TYPE_W   = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  ifetch_decode_queue_if.master bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
    dec_info_t         info;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  entry_t            queue_q [DEPTH];
  entry_t            queue_d [DEPTH];

  logic [PW-1:0]     count;
  logic [PW:0]       occupancy;
  logic              fetch, enq, deq, head_valid;
  entry_t            head, wr_entry;
  dec_info_t         wr_info;
  logic              unused_redirect_lsbs;

  ifd_decoder u_decoder (
    .instr (bus.imem_rdata),
    .info  (wr_info)
  );

  assign count      = wr_ptr_q - rd_ptr_q;
  // Slots already promised to an outstanding response count as occupied, so a request always has room.
  assign occupancy  = {1'b0, count} + {{PW{1'b0}}, inflight_q};
  assign fetch      = !rst_n && !bus.redirect_valid && (occupancy < (PW+1)'(DEPTH));
  assign enq        = bus.imem_rvalid && inflight_q;
  assign head_valid = (count != '0);
  assign deq        = head_valid && bus.dec_ready;
  assign head       = queue_q[rd_ptr_q[IW-1:0]];
  assign wr_entry   = '{pc: inflight_pc_q, instr: bus.imem_rdata, info: wr_info};
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = fetch;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q + PW'(enq);
    rd_ptr_d      = rd_ptr_q + PW'(deq);
    queue_d       = queue_q;
    if (enq) queue_d[wr_ptr_q[IW-1:0]] = wr_entry;
    if (fetch) begin
      pc_d          = pc_q + ADDR_W'(4);
      inflight_pc_d = pc_q;
    end
    // Redirect empties the queue; no request goes out this cycle, so nothing can land next cycle.
    if (bus.redirect_valid) begin
      pc_d     = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) queue_q[i] <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      queue_q       <= queue_d;
    end
  end

  assign bus.imem_req    = fetch;
  assign bus.imem_addr   = pc_q;
  assign bus.dec_valid   = head_valid;
  assign bus.dec_pc      = head_valid ? head.pc : '0;
  assign bus.dec_instr   = head_valid ? head.instr : 32'd0;
  assign bus.dec_type    = head_valid ? TYPE_W'(head.info.itype) : '0;
  assign bus.dec_format  = head_valid ? head.info.format : 5'b00000;
  assign bus.dec_illegal = head_valid && head.info.illegal;

endmodule

// File: tb/tb_ifetch_decode_queue.sv
// Bench for ifetch_decode_queue: decode vector table, directed latency/back-pressure/redirect/reset
// sequences, and a randomized run against a queue-level reference model.
module tb_ifetch_decode_queue;
  localparam int          ADDR_W   = 32;
  localparam int          TYPE_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk;
  logic rst_n;

  ifetch_decode_queue_if #(.ADDR_W(ADDR_W), .TYPE_W(TYPE_W)) bus ();

  ifetch_decode_queue #(
    .ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .DEPTH(DEPTH), .TYPE_W(TYPE_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: a flat list of encodings taken from the instruction table.
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         use_f3;
    bit         use_f7;
    int         tbit;
    logic [4:0] fmt;
  } pat_t;
  pat_t pats[$];

  function automatic void add_pat(logic [6:0] op, bit use_f3, logic [2:0] f3, bit use_f7, logic [6:0] f7,
                                  int tbit, logic [4:0] fmt);
    pat_t p;
    p.op = op; p.f3 = f3; p.f7 = f7; p.use_f3 = use_f3; p.use_f7 = use_f7; p.tbit = tbit; p.fmt = fmt;
    pats.push_back(p);
  endfunction

  function automatic void ref_decode(input logic [31:0] w, output logic [31:0] t, output logic [4:0] f,
                                     output logic ill);
    t = 32'd0; f = 5'd0; ill = 1'b1;
    foreach (pats[i]) begin
      if (w[6:0] == pats[i].op && (!pats[i].use_f3 || w[14:12] == pats[i].f3) &&
          (!pats[i].use_f7 || w[31:25] == pats[i].f7)) begin
        t = 32'd1 << pats[i].tbit; f = pats[i].fmt; ill = 1'b0;
      end
    end
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int k;
    w = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      k = $urandom_range(0, pats.size() - 1);
      w[6:0] = pats[k].op;
      if (pats[k].use_f3) w[14:12] = pats[k].f3;
      if (pats[k].use_f7 && $urandom_range(0, 4) != 0) w[31:25] = pats[k].f7;
    end
    return w;
  endfunction

  logic [31:0] mem [32];

  // Reference model state: expected queue contents packed as {pc, instr}.
  logic [63:0] exp_q[$];
  logic [31:0] m_pc = RESET_PC;
  bit          m_inflight = 0;
  logic [31:0] m_inflight_pc = '0;
  int          req_count = 0;

  // One clock: check outputs mid-cycle, advance the model, then answer last cycle's request after the edge.
  task automatic step();
    logic        exp_req, xfer, resp;
    logic [31:0] resp_addr, et;
    logic [4:0]  ef;
    logic        ei;
    @(negedge clk);
    exp_req = !rst_n && !bus.redirect_valid && ((exp_q.size() + int'(m_inflight)) < DEPTH);
    check("imem_req", bus.imem_req, exp_req);
    if (exp_req) check("imem_addr", bus.imem_addr, m_pc);
    check("dec_valid", bus.dec_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      ref_decode(exp_q[0][31:0], et, ef, ei);
      check("dec_pc", bus.dec_pc, exp_q[0][63:32]);
      check("dec_instr", bus.dec_instr, exp_q[0][31:0]);
      check("dec_type", bus.dec_type, et);
      check("dec_format_illegal", {bus.dec_format, bus.dec_illegal}, {ef, ei});
    end else begin
      check("empty_fields", {bus.dec_pc, bus.dec_instr}, 64'd0);
      check("empty_decode", {bus.dec_type, bus.dec_format, bus.dec_illegal}, 64'd0);
    end
    if (bus.imem_req) req_count++;
    xfer      = (exp_q.size() != 0) && bus.dec_ready;
    resp      = bus.imem_req;
    resp_addr = bus.imem_addr;
    if (rst_n) begin
      exp_q.delete();
      m_pc = RESET_PC;
      m_inflight = 0;
    end else begin
      if (xfer) void'(exp_q.pop_front());
      if (bus.redirect_valid) begin
        exp_q.delete();
        m_pc = {bus.redirect_pc[31:2], 2'b00};
        m_inflight = 0;
      end else begin
        if (bus.imem_rvalid && m_inflight) exp_q.push_back({m_inflight_pc, bus.imem_rdata});
        if (exp_req) begin
          m_inflight = 1; m_inflight_pc = m_pc; m_pc = m_pc + 32'd4;
        end else begin
          m_inflight = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    bus.imem_rvalid = resp;
    bus.imem_rdata  = resp ? mem[resp_addr[6:2]] : 32'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    bus.redirect_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int guard = 0;
    while (!bus.dec_valid && guard < 10) begin
      step();
      guard++;
    end
    check(name, bus.dec_valid, 1'b1);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] etype;
    logic [4:0]  efmt;
    logic        eill;
  } vec_t;
  vec_t vecs[14];

  initial begin
    rst_n = 1'b1;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.dec_ready = 1'b1;

    vecs[0]  = '{32'h00500093, 32'd1 << 16, 5'b01000, 1'b0};
    vecs[1]  = '{32'h40000033, 32'd1 << 7,  5'b10000, 1'b0};
    vecs[2]  = '{32'h00001063, 32'd1 << 19, 5'b00010, 1'b0};
    vecs[3]  = '{32'h00112023, 32'd1 << 17, 5'b00100, 1'b0};
    vecs[4]  = '{32'h0000006F, 32'd1 << 22, 5'b00001, 1'b0};
    vecs[5]  = '{32'h0000007F, 32'd0,       5'b00000, 1'b1};
`ifdef IFETCH_RV32M_EN
    vecs[6]  = '{32'h02208033, 32'd1 << 23, 5'b10000, 1'b0};
`else
    vecs[6]  = '{32'h02208033, 32'd0,       5'b00000, 1'b1};
`endif
    vecs[7]  = '{32'h00008067, 32'd1 << 21, 5'b01000, 1'b0};
    vecs[8]  = '{32'h00002003, 32'd1 << 18, 5'b01000, 1'b0};
    vecs[9]  = '{32'h40005013, 32'd1 << 9,  5'b01000, 1'b0};
    vecs[10] = '{32'h00003033, 32'd0,       5'b00000, 1'b1};
    vecs[11] = '{32'h40001013, 32'd0,       5'b00000, 1'b1};
    vecs[12] = '{32'h00006033, 32'd1 << 1,  5'b10000, 1'b0};
    vecs[13] = '{32'h00000063, 32'd1 << 20, 5'b00010, 1'b0};

    add_pat(7'h6F, 0, 3'd0, 0, 7'h00, 22, 5'b00001);
    add_pat(7'h67, 1, 3'd0, 0, 7'h00, 21, 5'b01000);
    add_pat(7'h63, 1, 3'd0, 0, 7'h00, 20, 5'b00010);
    add_pat(7'h63, 1, 3'd1, 0, 7'h00, 19, 5'b00010);
    add_pat(7'h03, 1, 3'd2, 0, 7'h00, 18, 5'b01000);
    add_pat(7'h23, 1, 3'd2, 0, 7'h00, 17, 5'b00100);
    add_pat(7'h13, 1, 3'd0, 0, 7'h00, 16, 5'b01000);
    add_pat(7'h13, 1, 3'd2, 0, 7'h00, 15, 5'b01000);
    add_pat(7'h13, 1, 3'd4, 0, 7'h00, 14, 5'b01000);
    add_pat(7'h13, 1, 3'd6, 0, 7'h00, 13, 5'b01000);
    add_pat(7'h13, 1, 3'd7, 0, 7'h00, 12, 5'b01000);
    add_pat(7'h13, 1, 3'd1, 1, 7'h00, 11, 5'b01000);
    add_pat(7'h13, 1, 3'd5, 1, 7'h00, 10, 5'b01000);
    add_pat(7'h13, 1, 3'd5, 1, 7'h20, 9,  5'b01000);
    add_pat(7'h33, 1, 3'd0, 1, 7'h00, 8,  5'b10000);
    add_pat(7'h33, 1, 3'd0, 1, 7'h20, 7,  5'b10000);
    add_pat(7'h33, 1, 3'd1, 1, 7'h00, 6,  5'b10000);
    add_pat(7'h33, 1, 3'd2, 1, 7'h00, 5,  5'b10000);
    add_pat(7'h33, 1, 3'd4, 1, 7'h00, 4,  5'b10000);
    add_pat(7'h33, 1, 3'd5, 1, 7'h00, 3,  5'b10000);
    add_pat(7'h33, 1, 3'd5, 1, 7'h20, 2,  5'b10000);
    add_pat(7'h33, 1, 3'd6, 1, 7'h00, 1,  5'b10000);
    add_pat(7'h33, 1, 3'd7, 1, 7'h00, 0,  5'b10000);
`ifdef IFETCH_RV32M_EN
    for (int f = 0; f < 8; f++) add_pat(7'h33, 1, 3'(f), 1, 7'h01, 23 + f, 5'b10000);
`endif

    // Reset values and first-fetch latency with a stream of ADDI.
    for (int i = 0; i < 32; i++) mem[i] = 32'h00500093;
    bus.dec_ready = 1'b1;
    rst_n = 1'b1;
    step();
    step();
    #1;
    check("rst_imem_req", bus.imem_req, 1'b0);
    check("rst_dec_valid", bus.dec_valid, 1'b0);
    check("rst_dec_pc_instr", {bus.dec_pc, bus.dec_instr}, 64'd0);
    check("rst_dec_decode", {bus.dec_type, bus.dec_format, bus.dec_illegal}, 64'd0);
    rst_n = 1'b0;
    #1;
    check("c0_req", bus.imem_req, 1'b1);
    check("c0_addr", bus.imem_addr, 32'h0);
    step();
    #1;
    check("c1_dec_valid", bus.dec_valid, 1'b0);
    check("c1_addr", bus.imem_addr, 32'h4);
    step();
    #1;
    check("c2_dec_valid", bus.dec_valid, 1'b1);
    check("c2_dec_pc", bus.dec_pc, 32'h0);
    check("c2_type", bus.dec_type, 32'd1 << 16);
    check("c2_format", bus.dec_format, 5'b01000);
    check("c2_addr", bus.imem_addr, 32'h8);

    // Decode vector table delivered in fetch order.
    for (int i = 0; i < 32; i++) mem[i] = (i < 14) ? vecs[i].instr : 32'h00500093;
    bus.dec_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      wait_valid("vec_timeout");
      check("vec_pc", bus.dec_pc, 32'(i * 4));
      check("vec_instr", bus.dec_instr, vecs[i].instr);
      check("vec_type", bus.dec_type, vecs[i].etype);
      check("vec_format", bus.dec_format, vecs[i].efmt);
      check("vec_illegal", bus.dec_illegal, vecs[i].eill);
      step();
    end

    // Back-pressure: exactly DEPTH requests, then drain in PC order.
    for (int i = 0; i < 32; i++) mem[i] = 32'h00500093 | (32'(i) << 20);
    bus.dec_ready = 1'b0;
    do_reset();
    req_count = 0;
    repeat (8) step();
    #1;
    check("bp_req_count", req_count, 4);
    check("bp_req_low", bus.imem_req, 1'b0);
    check("bp_valid_held", bus.dec_valid, 1'b1);
    bus.dec_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("bp_order_pc", bus.dec_pc, 32'(k * 4));
      check("bp_order_instr", bus.dec_instr, 32'h00500093 | (32'(k) << 20));
      step();
    end

    // Redirect with three entries queued and a response on the bus.
    bus.dec_ready = 1'b0;
    do_reset();
    repeat (4) step();
    #1;
    check("rd_pre_valid", bus.dec_valid, 1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    #1;
    check("rd_req_low", bus.imem_req, 1'b0);
    step();
    bus.redirect_valid = 1'b0;
    #1;
    check("rd_valid_drop", bus.dec_valid, 1'b0);
    check("rd_req", bus.imem_req, 1'b1);
    check("rd_addr", bus.imem_addr, 32'h100);
    bus.dec_ready = 1'b1;
    wait_valid("rd_timeout");
    check("rd_first_pc", bus.dec_pc, 32'h100);

    // Reset with a full queue, then a stray response right after reset.
    bus.dec_ready = 1'b0;
    do_reset();
    repeat (6) step();
    #1;
    check("mr_full_req", bus.imem_req, 1'b0);
    rst_n = 1'b1;
    step();
    #1;
    check("mr_valid", bus.dec_valid, 1'b0);
    rst_n = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'h0000006F;
    #1;
    check("mr_addr", bus.imem_addr, RESET_PC);
    step();
    #1;
    check("mr_stray_dropped", bus.dec_valid, 1'b0);
    bus.dec_ready = 1'b1;
    wait_valid("mr_timeout");
    check("mr_first_pc", bus.dec_pc, RESET_PC);
    check("mr_first_instr", bus.dec_instr, mem[0]);

    // Randomized traffic: back-pressure, redirects (some near the top of the address space), resets, stray responses.
    for (int i = 0; i < 32; i++) mem[i] = rand_word();
    bus.dec_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c % 300 == 299) for (int i = 0; i < 32; i++) mem[i] = rand_word();
      bus.dec_ready = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 24) == 0);
      bus.redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                    : 32'($urandom_range(0, 255));
      rst_n = ($urandom_range(0, 199) == 0);
      if (!bus.imem_rvalid && $urandom_range(0, 9) == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = $urandom;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
